// File: rtl/dft_result_writer_if.sv
// Bin stream from dft_core plus the write port of the downstream dft_fifo.
// The slave modport is the result writer's view; master is the environment's view.
interface dft_result_writer_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0]   data_re_in;
   logic [DATA_W-1:0]   data_im_in;
   logic                valid_in;
   logic [2*DATA_W-1:0] fifo_wdata;
   logic                fifo_wr;
   logic                fifo_full;

   modport master (
      output data_re_in, data_im_in, valid_in, fifo_full,
      input  fifo_wdata, fifo_wr
   );

   modport slave (
      input  data_re_in, data_im_in, valid_in, fifo_full,
      output fifo_wdata, fifo_wr
   );
endinterface

// File: rtl/dft_result_writer.sv
// Captures dft_core bin bursts into a frame ring buffer and drains each frame
// as a header word plus packed bin words into a dft_fifo write port.
module dft_result_writer #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned BINS_N     = 3,
   parameter int unsigned BUF_FRAMES = 4,
   parameter int unsigned SEQ_W      = 16,
   parameter logic [15:0] HDR_TAG    = 16'hA5A5
) (
   input  logic                    clk,
   input  logic                    rst,
   dft_result_writer_if.slave      bus,
   output logic [15:0]             drop_cnt,
   output logic                    short_burst,
   output logic                    busy
);

   localparam int unsigned IDX_W  = (BINS_N > 1) ? $clog2(BINS_N) : 1;
   localparam int unsigned SLOT_W = $clog2(BUF_FRAMES);
   localparam int unsigned OCC_W  = SLOT_W + 1;
   localparam int unsigned WORD_W = 2 * DATA_W;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BINS_N - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    k_q, k_d;
   logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
   logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                drop_q, drop_d;
   logic [SEQ_W-1:0]    seq_q, seq_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;
   logic                short_q, short_d;
   logic                fifo_wr_q, fifo_wr_d;
   logic [WORD_W-1:0]   fifo_wdata_q, fifo_wdata_d;

   logic [WORD_W-1:0]   mem_q [BUF_FRAMES][BINS_N];
   logic [SEQ_W-1:0]    seq_mem_q [BUF_FRAMES];

   logic                burst_start;
   logic                admit;
   logic                drop_now;
   logic                last_bin;
   logic                commit;
   logic                mem_we;
   logic                free_slot;
   logic                more_frames;
   logic [SEQ_W-1:0]    hdr_seq;
   logic [WORD_W-1:0]   hdr_word;

   // A slot finishing its drain on this edge is already free for admission.
   assign free_slot   = (state_q == ST_DATA) && !bus.fifo_full && (k_q == IDX_LAST);
   assign burst_start = bus.valid_in && (idx_q == '0);
   assign admit       = (occ_q != OCC_FULL) || free_slot;
   assign drop_now    = burst_start ? !admit : drop_q;
   assign last_bin    = bus.valid_in && (idx_q == IDX_LAST);
   assign commit      = last_bin && !drop_now;
   assign mem_we      = bus.valid_in && !drop_now;

   always_comb begin
      idx_d      = idx_q;
      drop_d     = drop_q;
      seq_d      = seq_q;
      wr_slot_d  = wr_slot_q;
      drop_cnt_d = drop_cnt_q;
      short_d    = short_q;
      if (bus.valid_in) begin
         if (burst_start) begin
            drop_d = !admit;
            if (!admit && (drop_cnt_q != 16'hFFFF)) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
         if (last_bin) begin
            idx_d = '0;
            seq_d = seq_q + SEQ_W'(1);
            if (commit) begin
               wr_slot_d = wr_slot_q + SLOT_W'(1);
            end
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else if (idx_q != '0) begin
         idx_d   = '0;
         short_d = 1'b1;
      end
   end

   assign occ_d = occ_q + OCC_W'(commit) - OCC_W'(free_slot);

   // An empty idle drain emits the header on the commit edge, taking the
   // sequence number straight from the counter rather than the slot store.
   assign hdr_seq     = ((state_q == ST_IDLE) && (occ_q == '0)) ? seq_q : seq_mem_q[rd_slot_q];
   assign hdr_word    = WORD_W'({HDR_TAG, hdr_seq});
   assign more_frames = (occ_q > OCC_W'(1)) || commit;

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      rd_slot_d    = rd_slot_q;
      fifo_wr_d    = 1'b0;
      fifo_wdata_d = fifo_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if ((occ_q != '0) || commit) begin
               if (!bus.fifo_full) begin
                  fifo_wr_d    = 1'b1;
                  fifo_wdata_d = hdr_word;
                  k_d          = '0;
                  state_d      = ST_DATA;
               end else begin
                  state_d = ST_HDR;
               end
            end
         end
         ST_HDR: begin
            if (!bus.fifo_full) begin
               fifo_wr_d    = 1'b1;
               fifo_wdata_d = hdr_word;
               k_d          = '0;
               state_d      = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!bus.fifo_full) begin
               fifo_wr_d    = 1'b1;
               fifo_wdata_d = mem_q[rd_slot_q][k_q];
               if (k_q == IDX_LAST) begin
                  k_d       = '0;
                  rd_slot_d = rd_slot_q + SLOT_W'(1);
                  state_d   = more_frames ? ST_HDR : ST_IDLE;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         rd_slot_q    <= '0;
         wr_slot_q    <= '0;
         occ_q        <= '0;
         idx_q        <= '0;
         drop_q       <= 1'b0;
         seq_q        <= '0;
         drop_cnt_q   <= '0;
         short_q      <= 1'b0;
         fifo_wr_q    <= 1'b0;
         fifo_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         rd_slot_q    <= rd_slot_d;
         wr_slot_q    <= wr_slot_d;
         occ_q        <= occ_d;
         idx_q        <= idx_d;
         drop_q       <= drop_d;
         seq_q        <= seq_d;
         drop_cnt_q   <= drop_cnt_d;
         short_q      <= short_d;
         fifo_wr_q    <= fifo_wr_d;
         fifo_wdata_q <= fifo_wdata_d;
      end
   end

   // Frame storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_slot_q][idx_q] <= {bus.data_re_in, bus.data_im_in};
      end
      if (commit) begin
         seq_mem_q[wr_slot_q] <= seq_q;
      end
   end

   assign bus.fifo_wr    = fifo_wr_q;
   assign bus.fifo_wdata = fifo_wdata_q;
   assign drop_cnt       = drop_cnt_q;
   assign short_burst    = short_q;
   assign busy           = (occ_q != '0) || (idx_q != '0);

endmodule
